// File: rtl/car_key_encoder.sv
// car_key_encoder: synchronises and debounces four active-low keys and runs the rear-light mode FSM
module car_key_encoder #(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int CNT_WIDTH    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  output logic [3:0] state_out,
  output logic       state_valid
);
  typedef enum logic [3:0] {
    STOP  = 4'b1111,
    GO    = 4'b1110,
    LEFT  = 4'b1101,
    RIGHT = 4'b1011,
    BACK  = 4'b0111
  } state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);
  state_t     r_state, w_next;
  logic [3:0] r_sync1, r_key_s, r_stable_d, w_stable, w_press;
  logic       w_single, r_valid;
  // two-flop synchroniser plus one-cycle history of the debounced keys for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync1    <= '1;
      r_key_s    <= '1;
      r_stable_d <= '1;
    end else begin
      r_sync1    <= key_n;
      r_key_s    <= r_sync1;
      r_stable_d <= w_stable;
    end
  for (genvar k = 0; k < 4; k++) begin : g_deb
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_stb;
    // accept a new key level only after it has differed from the stable level for DEBOUNCE_CNT cycles
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_cnt <= '0;
        r_stb <= 1'b1;
      end else if (r_key_s[k] == r_stb) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_stb <= r_key_s[k];
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    assign w_stable[k] = r_stb;
  end
  assign w_press  = r_stable_d & ~w_stable;
  assign w_single = (w_press != 4'b0) && ((w_press & (w_press - 4'b1)) == 4'b0);
  // a lone press selects its mode, except re-pressing the current mode or reversing GO/BACK falls to STOP
  always_comb begin
    w_next = r_state;
    w_next = !w_single ? r_state :
             (r_state == state_t'(~w_press) || (r_state == GO && w_press[3]) ||
              (r_state == BACK && w_press[0])) ? STOP : state_t'(~w_press);
  end
  // mode register and change strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= STOP;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next != r_state);
    end
  assign state_out   = r_state;
  assign state_valid = r_valid;
endmodule

// File: tb/tb_car_key_encoder.sv
// tb_car_key_encoder: directed checks of debounce, latency, mode transitions and reset
module tb_car_key_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'b1111;
  logic [3:0] state_out;
  logic       state_valid;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_strobe = 0;

  car_key_encoder #(.DEBOUNCE_CNT(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .state_out(state_out), .state_valid(state_valid)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (state_valid === 1'b1) n_strobe++;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_press(input logic [3:0] kn, output logic [3:0] s_before, output logic v_before,
                          output logic [3:0] s_at, output logic v_at, output logic v_after,
                          output int strobes);
    int s0;
    s0 = n_strobe;
    key_n = kn;
    cyc(6);
    s_before = state_out;
    v_before = state_valid;
    cyc(1);
    s_at = state_out;
    v_at = state_valid;
    cyc(1);
    v_after = state_valid;
    key_n = 4'b1111;
    cyc(10);
    strobes = n_strobe - s0;
  endtask

  task automatic test_reset;
    key_n = 4'($urandom);
    rst_n = 1'b0;
    cyc(3);
    n_cmp++;
    if (state_out !== 4'b1111 || state_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: state_out=%b valid=%b, required 1111/0", state_out, state_valid);
    end
    key_n = 4'b1111;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      n_cmp++;
      if (state_out !== 4'b1111 || state_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: state_out=%b valid=%b, required 1111/0", i, state_out, state_valid);
      end
    end
  endtask

  task automatic test_clean_press;
    logic [3:0] sb, sa;
    logic vb, va, vn;
    int ns;
    do_press(4'b1110, sb, vb, sa, va, vn, ns);
    n_cmp++;
    if (sb !== 4'b1111 || vb !== 1'b0) begin
      n_bad++;
      $display("FAIL go_edge6: state_out=%b valid=%b, required 1111/0", sb, vb);
    end
    n_cmp++;
    if (sa !== 4'b1110 || va !== 1'b1) begin
      n_bad++;
      $display("FAIL go_edge7: state_out=%b valid=%b, required 1110/1", sa, va);
    end
    n_cmp++;
    if (vn !== 1'b0 || ns !== 1) begin
      n_bad++;
      $display("FAIL go_strobe: valid_after=%b strobes=%0d, required 0/1", vn, ns);
    end
    do_press(4'b1110, sb, vb, sa, va, vn, ns);
    n_cmp++;
    if (sa !== 4'b1111 || va !== 1'b1 || ns !== 1) begin
      n_bad++;
      $display("FAIL go_toggle: state_out=%b valid=%b strobes=%0d, required 1111/1/1", sa, va, ns);
    end
  endtask

  task automatic test_bounce;
    int s0;
    s0 = n_strobe;
    key_n = 4'b1101; cyc(3);
    key_n = 4'b1111; cyc(1);
    key_n = 4'b1101; cyc(3);
    key_n = 4'b1111; cyc(10);
    n_cmp++;
    if (state_out !== 4'b1111 || n_strobe != s0) begin
      n_bad++;
      $display("FAIL bounce_reject: state_out=%b strobes=%0d, required 1111/0", state_out, n_strobe - s0);
    end
    s0 = n_strobe;
    key_n = 4'b1101; cyc(6);
    key_n = 4'b1111; cyc(10);
    n_cmp++;
    if (state_out !== 4'b1101 || n_strobe - s0 != 1) begin
      n_bad++;
      $display("FAIL bounce_accept: state_out=%b strobes=%0d, required 1101/1", state_out, n_strobe - s0);
    end
  endtask

  task automatic test_transitions;
    logic [3:0] kn [6] = '{4'b1110, 4'b1011, 4'b1101, 4'b0111, 4'b1110, 4'b1110};
    logic [3:0] ex [6] = '{4'b1110, 4'b1011, 4'b1101, 4'b0111, 4'b1111, 4'b1110};
    logic [3:0] sb, sa;
    logic vb, va, vn;
    int ns;
    for (int i = 0; i < 6; i++) begin
      do_press(kn[i], sb, vb, sa, va, vn, ns);
      n_cmp++;
      if (sa !== ex[i] || va !== 1'b1 || vb !== 1'b0 || ns !== 1) begin
        n_bad++;
        $display("FAIL trans[%0d]: state_out=%b valid=%b early_valid=%b strobes=%0d, required %b/1/0/1",
                 i, sa, va, vb, ns, ex[i]);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] sb, sa;
    logic vb, va, vn;
    int ns;
    do_press(4'b1110, sb, vb, sa, va, vn, ns);
    n_cmp++;
    if (sa !== 4'b1111) begin
      n_bad++;
      $display("FAIL simul_prep: state_out=%b, required 1111", sa);
    end
    do_press(4'b1100, sb, vb, sa, va, vn, ns);
    n_cmp++;
    if (state_out !== 4'b1111 || ns !== 0) begin
      n_bad++;
      $display("FAIL simul_ignored: state_out=%b strobes=%0d, required 1111/0", state_out, ns);
    end
    do_press(4'b1011, sb, vb, sa, va, vn, ns);
    n_cmp++;
    if (sa !== 4'b1011 || va !== 1'b1 || ns !== 1) begin
      n_bad++;
      $display("FAIL simul_after: state_out=%b valid=%b strobes=%0d, required 1011/1/1", sa, va, ns);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] sb, sa;
    logic vb, va, vn;
    int ns;
    do_press(4'b1101, sb, vb, sa, va, vn, ns);
    n_cmp++;
    if (sa !== 4'b1101) begin
      n_bad++;
      $display("FAIL arst_prep: state_out=%b, required 1101", sa);
    end
    key_n = 4'b0111;
    cyc(4);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state_out !== 4'b1111 || state_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_immediate: state_out=%b valid=%b, required 1111/0", state_out, state_valid);
    end
    #2 rst_n = 1'b1;
    cyc(6);
    n_cmp++;
    if (state_out !== 4'b1111 || state_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_edge6: state_out=%b valid=%b, required 1111/0", state_out, state_valid);
    end
    cyc(1);
    n_cmp++;
    if (state_out !== 4'b0111 || state_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_edge7: state_out=%b valid=%b, required 0111/1", state_out, state_valid);
    end
    cyc(3);
    n_cmp++;
    if (state_out !== 4'b0111 || state_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_held: state_out=%b valid=%b, required 0111/0", state_out, state_valid);
    end
    key_n = 4'b1111;
    cyc(10);
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_transitions;
    test_simultaneous;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
